// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell and a carry flop, LSB first.
// Latency WIDTH edges from accept to result; start is accepted only in IDLE, never queued.
module serial_adder_n #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic             i_sub,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_s,
   output logic             o_cout,
   output logic             o_ovf
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic [WIDTH-1:0] sum_nx;
   logic             c;
   logic             c_nx;
   logic             s_bit;
   logic [CW-1:0]    cnt;
   logic             last_bit;
   logic             accept;

   // Single full-adder cell operating on the current LSBs.
   always_comb begin
      s_bit    = a_sr[0] ^ b_sr[0] ^ c;
      c_nx     = (a_sr[0] & b_sr[0]) | (a_sr[0] & c) | (b_sr[0] & c);
      sum_nx   = WIDTH'({s_bit, sum_sr} >> 1);
      last_bit = (cnt == CW'(WIDTH - 1));
      accept   = (state == IDLE) && i_start;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (i_start) state_nx = RUN;
         RUN:     if (last_bit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         o_s    <= '0;
         o_cout <= 1'b0;
         o_ovf  <= 1'b0;
      end else if (accept) begin
         // Subtraction runs as a + ~b + ~borrow_in through the same cell.
         a_sr <= i_a;
         b_sr <= i_sub ? ~i_b : i_b;
         c    <= i_cin ^ i_sub;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr   <= a_sr >> 1;
         b_sr   <= b_sr >> 1;
         sum_sr <= sum_nx;
         c      <= c_nx;
         cnt    <= cnt + CW'(1);
         if (last_bit) begin
            // On the last bit, c is the carry entering the MSB.
            o_s    <= sum_nx;
            o_cout <= c_nx;
            o_ovf  <= c ^ c_nx;
         end
      end
   end

   assign o_busy = (state == RUN);
   assign o_done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_n.sv
// Self-checking bench for serial_adder_n at WIDTH 1, 8 and 32 against an arithmetic model.
module tb_serial_adder_n;

   logic clk = 1'b0;
   logic rst_n;

   logic        start1, sub1, cin1, busy1, done1, cout1, ovf1;
   logic [0:0]  a1, b1, s1;
   logic        start8, sub8, cin8, busy8, done8, cout8, ovf8;
   logic [7:0]  a8, b8, s8;
   logic        start32, sub32, cin32, busy32, done32, cout32, ovf32;
   logic [31:0] a32, b32, s32;

   int n_eval = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder_n #(.WIDTH(1)) u1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .i_sub(sub1), .i_a(a1), .i_b(b1),
      .i_cin(cin1), .o_busy(busy1), .o_done(done1), .o_s(s1), .o_cout(cout1), .o_ovf(ovf1));

   serial_adder_n #(.WIDTH(8)) u8 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_sub(sub8), .i_a(a8), .i_b(b8),
      .i_cin(cin8), .o_busy(busy8), .o_done(done8), .o_s(s8), .o_cout(cout8), .o_ovf(ovf8));

   serial_adder_n #(.WIDTH(32)) u32 (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start32), .i_sub(sub32), .i_a(a32), .i_b(b32),
      .i_cin(cin32), .o_busy(busy32), .o_done(done32), .o_s(s32), .o_cout(cout32), .o_ovf(ovf32));

   // Reference: exact integer arithmetic; returns {ovf, cout, s[31:0]}.
   function automatic logic [33:0] ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                             input logic sub, input logic cin);
      longint full, half, ua, ub, sa, sb, ux, ex;
      logic   cout, ovf;
      logic [31:0] s;
      full = longint'(1) << w;
      half = longint'(1) << (w - 1);
      ua   = longint'(a) & (full - 1);
      ub   = longint'(b) & (full - 1);
      sa   = (ua >= half) ? ua - full : ua;
      sb   = (ub >= half) ? ub - full : ub;
      ux   = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
      ex   = sub ? sa - sb - longint'(cin) : sa + sb + longint'(cin);
      cout = sub ? (ux >= 0) : (ux >= full);
      ovf  = (ex >= half) || (ex < -half);
      s    = 32'(ux & (full - 1));
      return {ovf, cout, s};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_eval++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input int w, input logic st, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin);
      case (w)
         1: begin start1 = st; a1 = a[0:0]; b1 = b[0:0]; sub1 = sub; cin1 = cin; end
         8: begin start8 = st; a8 = a[7:0]; b8 = b[7:0]; sub8 = sub; cin8 = cin; end
         default: begin start32 = st; a32 = a; b32 = b; sub32 = sub; cin32 = cin; end
      endcase
   endtask

   function automatic logic [31:0] get_s(input int w);
      case (w)
         1: return 32'(s1);
         8: return 32'(s8);
         default: return s32;
      endcase
   endfunction

   function automatic logic [3:0] get_flags(input int w);  // {busy, done, cout, ovf}
      case (w)
         1: return {busy1, done1, cout1, ovf1};
         8: return {busy8, done8, cout8, ovf8};
         default: return {busy32, done32, cout32, ovf32};
      endcase
   endfunction

   // Called at a negedge; returns at the negedge one cycle after the done pulse.
   task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic cin, input bit hold, input string tag);
      logic [33:0] exp;
      logic [31:0] prev;
      logic [3:0]  f;
      int k;
      exp  = ref_model(w, a, b, sub, cin);
      prev = get_s(w);
      set_in(w, 1'b1, a, b, sub, cin);
      @(negedge clk);
      set_in(w, hold, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      k = 0;
      f = get_flags(w);
      while (!f[2] && k < w + 4) begin
         check({tag, "_busy"}, 32'(f[3]), 32'd1);
         check({tag, "_s_hold"}, get_s(w), prev);
         @(negedge clk);
         k++;
         f = get_flags(w);
      end
      check({tag, "_latency"}, k, w);
      check({tag, "_done"}, 32'(f[2]), 32'd1);
      check({tag, "_busy_in_done"}, 32'(f[3]), 32'd0);
      check({tag, "_s"}, get_s(w), exp[31:0]);
      check({tag, "_cout"}, 32'(f[1]), 32'(exp[32]));
      check({tag, "_ovf"}, 32'(f[0]), 32'(exp[33]));
      @(negedge clk);
      f = get_flags(w);
      check({tag, "_idle_busy"}, 32'(f[3]), 32'd0);
      check({tag, "_idle_done"}, 32'(f[2]), 32'd0);
   endtask

   initial begin
      logic [3:0] f;
      rst_n = 1'b0;
      set_in(1, 0, 0, 0, 0, 0);
      set_in(8, 0, 0, 0, 0, 0);
      set_in(32, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      f = get_flags(8);
      check("reset_flags8", 32'(f), 32'd0);
      check("reset_s8", get_s(8), 32'd0);
      f = get_flags(32);
      check("reset_flags32", 32'(f), 32'd0);
      rst_n = 1'b1;

      // WIDTH=1 full-adder truth table
      for (int i = 0; i < 8; i++) begin
         logic [2:0] v;
         v = 3'(i);
         run_op(1, 32'(v[2]), 32'(v[1]), 1'b0, v[0], 0, "fa1");
      end

      // WIDTH=8 directed add/sub
      run_op(8, 32'h0F, 32'h01, 1'b0, 1'b0, 0, "add_0f_01");
      run_op(8, 32'hFF, 32'h01, 1'b0, 1'b0, 0, "add_ff_01");
      run_op(8, 32'h7F, 32'h01, 1'b0, 1'b0, 0, "add_7f_01");
      run_op(8, 32'h05, 32'h07, 1'b1, 1'b0, 0, "sub_05_07");
      run_op(8, 32'h80, 32'h01, 1'b1, 1'b0, 0, "sub_80_01");
      run_op(8, 32'h10, 32'h01, 1'b1, 1'b1, 0, "sub_10_01_b");

      // Start held high across two back-to-back operations
      run_op(8, 32'h3C, 32'h21, 1'b0, 1'b0, 1, "hold1");
      run_op(8, 32'h44, 32'h04, 1'b1, 1'b0, 1, "hold2");
      set_in(8, 0, 0, 0, 0, 0);

      // Async reset in the middle of an operation
      @(negedge clk);
      set_in(8, 1, 32'h55, 32'h0A, 1'b0, 1'b0);
      @(negedge clk);
      set_in(8, 0, 0, 0, 0, 0);
      repeat (4) @(negedge clk);
      f = get_flags(8);
      check("midrst_pre_busy", 32'(f[3]), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      f = get_flags(8);
      check("midrst_flags", 32'(f), 32'd0);
      check("midrst_s", get_s(8), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8, 32'h22, 32'h11, 1'b0, 1'b0, 0, "post_rst");

      // WIDTH=32 random sweep
      for (int i = 0; i < 1000; i++) begin
         run_op(32, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "rnd32");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_eval, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder_n.md
# serial_adder_n

Parametrised bit-serial adder/subtractor that extends the single-bit full adder to WIDTH-bit operands. It reuses one full-adder cell and a carry flip-flop, processing one bit per clock, LSB first. A start/busy/done handshake surrounds the datapath. It sits between register-file operand latches and the result bus in area-constrained datapaths, where one full adder plus state is cheaper than a WIDTH-bit ripple adder.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 1..32
- i_clk  input  1  clock; all state changes on rising edge
- i_rst_n  input  1  asynchronous, active-low reset
- i_start  input  1  request; sampled only in IDLE
- i_sub  input  1  0 = add, 1 = subtract (a - b); latched with operands
- i_a  input  WIDTH  operand A; latched on accepted start
- i_b  input  WIDTH  operand B; latched on accepted start
- i_cin  input  1  carry-in (add) or borrow-in (sub)
- o_busy  output  1  high while bits are being processed (RUN)
- o_done  output  1  one-cycle pulse; result valid
- o_s  output  WIDTH  result; held until the next result
- o_cout  output  1  carry out of MSB (sub: 1 = no borrow)
- o_ovf  output  1  two's-complement overflow

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE. All outputs and internal registers reset to 0.
- IDLE: if i_start=1, the block captures:
  - A into the shift register a_sr.
  - B, or ~B when i_sub=1, into b_sr.
  - Initial carry c = i_cin XOR i_sub.
  - Bit counter = 0.
  - Transition to RUN. Otherwise stay in IDLE.
- Subtract semantics: a + ~b + (1 - i_cin), giving a - b - borrow_in.
- RUN, on each edge:
  - Compute s_bit = a_sr[0] ^ b_sr[0] ^ c and c_next = majority(a_sr[0], b_sr[0], c).
  - Shift a_sr and b_sr right by one. Shift s_bit into the MSB of the internal sum register.
  - c <= c_next. Record the carry into the MSB (the c value entering bit WIDTH-1) for overflow.
  - Counter increments. On the edge that processes bit WIDTH-1, go to DONE.
- DONE transition edge:
  - o_s <= final sum register.
  - o_cout <= final carry.
  - o_ovf <= carry_into_msb XOR final carry.
- DONE lasts exactly one cycle with o_done=1, then returns to IDLE unconditionally.
- i_start is ignored in RUN and DONE; no queuing.
- i_a, i_b, i_sub and i_cin may change freely after the accepting edge; only the latched copies are used.
- o_s, o_cout and o_ovf change only on the DONE transition edge. They are stable in all other cycles, including during RUN of the next operation.
- WIDTH=1: behaviour equals the 1-bit full adder (add mode), with a one-bit RUN.
- Counter width: clog2(WIDTH)+1 bits, so no wrap for WIDTH up to 32.

## Timing
- Start accepted on edge E0. o_busy=1 after E0, held through E_WIDTH.
- Bits are processed on edges E1..E_WIDTH. State is DONE after E_WIDTH.
- o_done=1 for the single cycle between E_WIDTH and E_WIDTH+1. o_busy is 0 in that cycle.
- Earliest next accept is on E_WIDTH+2 (back in IDLE). Throughput is one operation per WIDTH+2 cycles.
- Latency from accepting edge to result visible: WIDTH edges.
- Async reset mid-operation: immediately (not clock-aligned) forces IDLE and clears o_busy, o_done, o_s, o_cout and o_ovf to 0. The partial result is discarded.
- Deassertion of i_rst_n is synchronised externally. The first accepted start may occur on the first edge after release.

## Test plan
- WIDTH=1, all 8 combinations of i_a, i_b, i_cin with i_sub=0 -> o_s/o_cout match the full-adder truth table, e.g. 1+1+1 -> o_s=1, o_cout=1. o_done arrives 1 edge after accept.
- WIDTH=8 add: 0x0F+0x01, cin=0 -> o_s=0x10, cout=0, ovf=0. 0xFF+0x01 -> 0x00, cout=1, ovf=0. 0x7F+0x01 -> 0x80, cout=0, ovf=1. Check o_done exactly 8 edges after accept, o_busy high for 8 cycles.
- WIDTH=8 sub: 0x05-0x07, cin=0 -> o_s=0xFE, cout=0, ovf=0. 0x80-0x01 -> 0x7F, cout=1, ovf=1. 0x10-0x01 with borrow-in cin=1 -> 0x0E, cout=1.
- Handshake: hold i_start=1 continuously and change i_a/i_b during RUN -> a single result from the latched operands. Next accept occurs only after the DONE cycle. o_s is unchanged during the second RUN until its DONE.
- Reset mid-op: assert i_rst_n=0 at bit 4 of 8 -> all outputs 0 immediately. After release, a fresh 0x22+0x11 -> o_s=0x33.
- WIDTH=32 random sweep (≥1000 ops, mixed i_sub/i_cin) against a reference model -> o_s, o_cout and o_ovf all match.
